// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared state type, default seed and LFSR tap table for dice_rng
package dice_pkg;

  // Reset seed; also replaces any all-zero seed, which would lock the LFSR.
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } state_e;

  // Maximal-length Galois tap masks for the supported LFSR widths.
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] t;
    case (w)
      8:       t = 32'h0000_00B8;
      16:      t = 32'h0000_B400;
      24:      t = 32'h00E1_0000;
      32:      t = 32'hA300_0000;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// rtl/lfsr_galois.sv - right-shifting Galois LFSR with synchronous load
module lfsr_galois #(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = W'(32'h0000_B400),
  parameter logic [W-1:0] SEED = W'(32'h0000_ACE1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Load wins over stepping; a step shifts right and folds the taps in when bit 0 leaves as 1.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = q_q[0] ? ((q_q >> 1) ^ TAPS) : (q_q >> 1);
    end
  end

  // State register, returns to the seed on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dice_rng.sv
// rtl/dice_rng.sv - die roller: LFSR draws with rejection sampling and bounded retries
module dice_rng
  import dice_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter int                SIDES     = 6,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
  parameter int                MAX_TRIES = 8,
  localparam int               K         = $clog2(SIDES),
  localparam int               OUT_W     = $clog2(SIDES + 1),
  localparam int               TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_value,
  output logic [OUT_W-1:0]  result,
  output logic              done,
  output logic              busy,
  output logic              biased,
  output logic [TRY_W-1:0]  tries,
  output logic              bit_out
);

  localparam logic [31:0]       TAPS_ALL = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] K_MASK   = LFSR_W'((64'd1 << K) - 64'd1);
  localparam logic [OUT_W-1:0]  SIDES_V  = OUT_W'(SIDES);
  localparam logic [TRY_W-1:0]  MAX_V    = TRY_W'(MAX_TRIES);

  state_e             state_q, state_d;
  logic [TRY_W-1:0]   count_q, count_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [OUT_W-1:0]   result_q, result_d;
  logic               biased_q, biased_d;
  logic               done_q, done_d;

  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  lfsr_next;
  logic [LFSR_W-1:0]  load_val;
  logic [LFSR_W-1:0]  cand_w;
  logic [OUT_W-1:0]   cand;
  logic               lfsr_en;
  logic               lfsr_load;

  // Seed loads are only honoured while idle; a zero seed would stall the LFSR, so it is replaced.
  assign lfsr_load = (state_q == ST_IDLE) && seed_load;
  assign lfsr_en   = (state_q == ST_DRAW);
  assign load_val  = (seed_value == '0) ? SEED : seed_value;

  lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .en       (lfsr_en),
    .load     (lfsr_load),
    .load_val (load_val),
    .q        (lfsr)
  );

  // The candidate comes from the value the LFSR is stepping to this cycle, not the current one.
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign cand_w    = lfsr_next & K_MASK;
  assign cand      = OUT_W'(cand_w);

  // Roll sequencing: accept in-range candidates, fold on the last allowed draw, otherwise retry.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    tries_d  = tries_q;
    biased_d = biased_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!seed_load && start) begin
          state_d = ST_DRAW;
          count_d = TRY_W'(1);
        end
      end
      ST_DRAW: begin
        if (cand < SIDES_V) begin
          result_d = cand + OUT_W'(1);
          biased_d = 1'b0;
          tries_d  = count_q;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (count_q == MAX_V) begin
          // cand < 2**K <= 2*SIDES, so subtracting SIDES lands back in 0..SIDES-1.
          result_d = (cand - SIDES_V) + OUT_W'(1);
          biased_d = 1'b1;
          tries_d  = count_q;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          count_d = count_q + TRY_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered roll state; reset abandons any roll in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      result_q <= OUT_W'(1);
      tries_q  <= '0;
      biased_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      tries_q  <= tries_d;
      biased_q <= biased_d;
      done_q   <= done_d;
    end
  end

  assign result  = result_q;
  assign done    = done_q;
  assign busy    = (state_q == ST_DRAW);
  assign biased  = biased_q;
  assign tries   = tries_q;
  assign bit_out = lfsr[0];

endmodule

// File: tb/tb_dice_rng.sv
// tb/tb_dice_rng.sv - scoreboard bench for dice_rng against a behavioural roll model
module tb_dice_rng;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, seed_load;
  logic [15:0] seed_value;
  logic [2:0]  result;
  logic        done, busy, biased, bit_out;
  logic [3:0]  tries;

  logic        start1, seed_load1;
  logic [15:0] seed_value1;
  logic [2:0]  result1;
  logic        done1, busy1, biased1, bit_out1;
  logic [0:0]  tries1;

  dice_rng #(.LFSR_W(16), .SIDES(6), .SEED(16'hACE1), .MAX_TRIES(8)) dut (
    .clk(clk), .reset(reset), .start(start), .seed_load(seed_load), .seed_value(seed_value),
    .result(result), .done(done), .busy(busy), .biased(biased), .tries(tries), .bit_out(bit_out)
  );

  dice_rng #(.LFSR_W(16), .SIDES(6), .SEED(16'hACE1), .MAX_TRIES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .seed_load(seed_load1), .seed_value(seed_value1),
    .result(result1), .done(done1), .busy(busy1), .biased(biased1), .tries(tries1), .bit_out(bit_out1)
  );

  typedef struct {
    int res;
    int tr;
    int bias;
    int lsb;
    int end_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          hist_on = 1'b0;
  int          hist[7];
  int          out_of_range = 0;
  logic [15:0] m_lfsr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: draw uniformly over 3 bits of the 16-bit maximal LFSR, reject >= 6, fold on the last try.
  function automatic logic [15:0] step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic exp_t predict(inout logic [15:0] l, input int max_tries);
    exp_t e;
    int   c;
    bit   fin;
    e   = '{default: 0};
    fin = 1'b0;
    for (int t = 1; t <= max_tries && !fin; t++) begin
      l = step(l);
      c = int'(l) % 8;
      if (c < 6) begin
        e.res = c + 1; e.tr = t; e.bias = 0; fin = 1'b1;
      end else if (t == max_tries) begin
        e.res = c - 6 + 1; e.tr = t; e.bias = 1; fin = 1'b1;
      end
    end
    e.lsb = int'(l[0]);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no roll outstanding", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", int'(result), mon_e.res);
        check("tries", int'(tries), mon_e.tr);
        check("biased", int'(biased), mon_e.bias);
        check("bit_out_at_done", int'(bit_out), mon_e.lsb);
        check("done_latency", cyc, mon_e.end_cyc);
        if (hist_on) begin
          if (result >= 3'd1 && result <= 3'd6) hist[result]++;
          else out_of_range++;
        end
      end
    end
  end

  task automatic load_seed(input logic [15:0] v);
    seed_load  = 1'b1;
    seed_value = v;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr = (v == 16'h0) ? 16'hACE1 : v;
  endtask

  task automatic issue_start();
    exp_t e;
    e = predict(m_lfsr, 8);
    e.end_cyc = cyc + 1 + e.tr;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL roll_timeout: got busy=1 after %0d cycles expected idle", n);
    end
  endtask

  task automatic roll_directed(input logic [15:0] s, input int r, input int t, input int b);
    load_seed(s);
    issue_start();
    wait_idle();
    check("dir_result", int'(result), r);
    check("dir_tries", int'(tries), t);
    check("dir_biased", int'(biased), b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, int'(result), 1);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_biased"}, int'(biased), 0);
    check({tag, "_tries"}, int'(tries), 0);
    check({tag, "_bit_out"}, int'(bit_out), 1);
  endtask

  initial begin
    int n;
    int r;
    reset = 1'b1; start = 1'b0; seed_load = 1'b0; seed_value = '0;
    start1 = 1'b0; seed_load1 = 1'b0; seed_value1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");

    // First roll from the reset seed confirms the LFSR did not move while idle.
    m_lfsr = 16'hACE1;
    issue_start();
    wait_idle();

    roll_directed(16'h0001, 1, 1, 0);
    roll_directed(16'h000F, 4, 2, 0);

    // Zero seed is replaced by the default seed.
    load_seed(16'h0000);
    check("zero_seed_bit_out", int'(bit_out), 1);
    issue_start();
    wait_idle();

    // seed_load and start together: seed taken, roll not started.
    seed_load = 1'b1; seed_value = 16'h0001; start = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; start = 1'b0;
    m_lfsr = 16'h0001;
    check("load_and_start_busy", int'(busy), 0);
    @(negedge clk);
    check("load_and_start_busy2", int'(busy), 0);
    issue_start();
    wait_idle();
    check("after_load_start_result", int'(result), 1);

    // start and seed_load during DRAW are ignored.
    load_seed(16'h000F);
    issue_start();
    start = 1'b1; seed_load = 1'b1; seed_value = 16'h1234;
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0;
    wait_idle();
    check("draw_ignore_result", int'(result), 4);
    check("draw_ignore_tries", int'(tries), 2);
    repeat (3) @(negedge clk);
    issue_start();
    wait_idle();

    // Reset mid-roll: no done pulse, outputs back to reset values.
    load_seed(16'h000F);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("post_reset_no_done", int'(done), 0);
      @(negedge clk);
    end
    check_reset_outputs("midroll_reset");
    m_lfsr = 16'hACE1;

    // Randomised mix of seed loads, idle gaps and rolls.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        load_seed(($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom));
      end else if (r == 1) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end else begin
        issue_start();
        wait_idle();
      end
    end

    // 1000 back-to-back rolls for the face distribution.
    load_seed(16'($urandom) | 16'h0001);
    hist_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      issue_start();
      wait_idle();
    end
    @(negedge clk);
    hist_on = 1'b0;
    for (int f = 1; f <= 6; f++) begin
      checks++;
      if (hist[f] < 125 || hist[f] > 209) begin
        errors++;
        $display("FAIL face_%0d_count: got %0d expected 125..209", f, hist[f]);
      end
    end
    check("out_of_range_results", out_of_range, 0);

    // MAX_TRIES=1 instance: first candidate 7 is folded to face 2.
    seed_load1 = 1'b1; seed_value1 = 16'h000F;
    @(negedge clk);
    seed_load1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fold_done_seen", int'(done1), 1);
    check("fold_latency_cycles", n, 1);
    check("fold_result", int'(result1), 2);
    check("fold_biased", int'(biased1), 1);
    check("fold_tries", int'(tries1), 1);
    @(negedge clk);
    check("fold_done_single_cycle", int'(done1), 0);
    check("fold_result_held", int'(result1), 2);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
